// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions used by both the read and write pointer blocks.
// Gray helpers work on a wide word; callers zero-extend and slice to their pointer width.
package fifo_pkg;

    localparam int ADDR_SIZE_DEF = 4;
    localparam int MAX_PTR_W     = 16;

    typedef logic [MAX_PTR_W-1:0] ptr_word_t;

    function automatic int ptr_width(input int addr_size);
        return addr_size + 1;
    endfunction

    localparam int PTR_W_DEF = ptr_width(ADDR_SIZE_DEF);

    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return (bin >> 1) ^ bin;
    endfunction

    // Zero-extended upper bits leave the prefix XOR unaffected.
    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/sync_ptr.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
module sync_ptr #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ptr,
    output logic [WIDTH-1:0] ptr_sync
);

    logic [WIDTH-1:0] stage1;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage1   <= '0;
            ptr_sync <= '0;
        end else begin
            stage1   <= ptr;
            ptr_sync <= stage1;
        end
    end

endmodule

// File: rtl/read_empty.sv
// Read-side pointer and flag logic of an async FIFO: pops, empty/almost-empty, occupancy, underflow.
// Flags are computed from next-state pointers so they are valid in the same cycle as the pointer.
module read_empty
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int AE_LEVEL  = 2
) (
    input  logic                 read_clk,
    input  logic                 read_reset,
    input  logic                 read_inc,
    input  logic [ADDR_SIZE:0]   write_ptr,
    output logic [ADDR_SIZE-1:0] read_addr,
    output logic [ADDR_SIZE:0]   read_ptr,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   read_count,
    output logic                 underflow
);

    localparam int PTR_W = ptr_width(ADDR_SIZE);
    localparam logic [PTR_W-1:0] AE_THR = PTR_W'(AE_LEVEL);

    logic [PTR_W-1:0] wptr_sync;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] rgray;
    logic [PTR_W-1:0] next_rbin;
    logic [PTR_W-1:0] next_rgray;
    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] next_count;
    ptr_word_t        gray_wide;
    ptr_word_t        wbin_wide;
    logic             pop;
    logic             unused_hi;

    sync_ptr #(.WIDTH(PTR_W)) u_sync_wptr (
        .clk      (read_clk),
        .reset    (read_reset),
        .ptr      (write_ptr),
        .ptr_sync (wptr_sync)
    );

    always_comb begin
        pop        = read_inc & ~empty;
        next_rbin  = rbin + PTR_W'(pop);
        gray_wide  = bin2gray(ptr_word_t'(next_rbin));
        next_rgray = gray_wide[PTR_W-1:0];
        wbin_wide  = gray2bin(ptr_word_t'(wptr_sync));
        wbin       = wbin_wide[PTR_W-1:0];
        next_count = wbin - next_rbin;
    end

    assign unused_hi = ^{gray_wide[MAX_PTR_W-1:PTR_W], wbin_wide[MAX_PTR_W-1:PTR_W]};

    always_ff @(posedge read_clk) begin
        if (read_reset) begin
            rbin         <= '0;
            rgray        <= '0;
            read_count   <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            underflow    <= 1'b0;
        end else begin
            rbin         <= next_rbin;
            rgray        <= next_rgray;
            read_count   <= next_count;
            empty        <= (next_rgray == wptr_sync);
            almost_empty <= (next_count <= AE_THR);
            if (read_inc && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    assign read_addr = rbin[ADDR_SIZE-1:0];
    assign read_ptr  = rgray;

endmodule

// File: tb/tb_read_empty.sv
// Directed bench for read_empty at ADDR_SIZE=4, AE_LEVEL=2; inputs change and outputs are sampled on negedge.
module tb_read_empty;

    logic       read_clk;
    logic       read_reset;
    logic       read_inc;
    logic [4:0] write_ptr;
    logic [3:0] read_addr;
    logic [4:0] read_ptr;
    logic       empty;
    logic       almost_empty;
    logic [4:0] read_count;
    logic       underflow;

    int vecs = 0;
    int errs = 0;

    read_empty #(.ADDR_SIZE(4), .AE_LEVEL(2)) dut (
        .read_clk     (read_clk),
        .read_reset   (read_reset),
        .read_inc     (read_inc),
        .write_ptr    (write_ptr),
        .read_addr    (read_addr),
        .read_ptr     (read_ptr),
        .empty        (empty),
        .almost_empty (almost_empty),
        .read_count   (read_count),
        .underflow    (underflow)
    );

    initial read_clk = 1'b0;
    always #5 read_clk = ~read_clk;

    task automatic step(input int n);
        repeat (n) @(negedge read_clk);
    endtask

    task automatic apply_reset();
        read_reset = 1'b1;
        read_inc   = 1'b0;
        write_ptr  = 5'b00000;
        step(2);
        read_reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL reset_empty got=%b want=1", empty); end
        vecs++; if (almost_empty !== 1'b1) begin errs++; $display("FAIL reset_ae got=%b want=1", almost_empty); end
        vecs++; if (read_addr !== 4'd0) begin errs++; $display("FAIL reset_addr got=%0d want=0", read_addr); end
        vecs++; if (read_ptr !== 5'b00000) begin errs++; $display("FAIL reset_ptr got=%b want=00000", read_ptr); end
        vecs++; if (read_count !== 5'd0) begin errs++; $display("FAIL reset_count got=%0d want=0", read_count); end
        vecs++; if (underflow !== 1'b0) begin errs++; $display("FAIL reset_underflow got=%b want=0", underflow); end
    endtask

    task automatic test_single_entry();
        apply_reset();
        write_ptr = 5'b00001;
        step(1);
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL single_edge1_empty got=%b want=1", empty); end
        step(1);
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL single_edge2_empty got=%b want=1", empty); end
        vecs++; if (read_count !== 5'd0) begin errs++; $display("FAIL single_edge2_count got=%0d want=0", read_count); end
        step(1);
        vecs++; if (empty !== 1'b0) begin errs++; $display("FAIL single_edge3_empty got=%b want=0", empty); end
        vecs++; if (read_count !== 5'd1) begin errs++; $display("FAIL single_edge3_count got=%0d want=1", read_count); end
        read_inc = 1'b1;
        step(1);
        read_inc = 1'b0;
        vecs++; if (read_addr !== 4'd1) begin errs++; $display("FAIL single_pop_addr got=%0d want=1", read_addr); end
        vecs++; if (read_ptr !== 5'b00001) begin errs++; $display("FAIL single_pop_ptr got=%b want=00001", read_ptr); end
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL single_pop_empty got=%b want=1", empty); end
        vecs++; if (read_count !== 5'd0) begin errs++; $display("FAIL single_pop_count got=%0d want=0", read_count); end
        vecs++; if (underflow !== 1'b0) begin errs++; $display("FAIL single_pop_underflow got=%b want=0", underflow); end
    endtask

    task automatic test_underflow();
        apply_reset();
        read_inc = 1'b1;
        step(3);
        vecs++; if (read_addr !== 4'd0) begin errs++; $display("FAIL uf_addr got=%0d want=0", read_addr); end
        vecs++; if (read_ptr !== 5'b00000) begin errs++; $display("FAIL uf_ptr got=%b want=00000", read_ptr); end
        vecs++; if (underflow !== 1'b1) begin errs++; $display("FAIL uf_set got=%b want=1", underflow); end
        read_inc = 1'b0;
        step(2);
        vecs++; if (underflow !== 1'b1) begin errs++; $display("FAIL uf_sticky got=%b want=1", underflow); end
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL uf_empty got=%b want=1", empty); end
    endtask

    task automatic test_wrap();
        apply_reset();
        write_ptr = 5'b11000;
        step(3);
        vecs++; if (read_count !== 5'd16) begin errs++; $display("FAIL wrap_full_count got=%0d want=16", read_count); end
        vecs++; if (empty !== 1'b0) begin errs++; $display("FAIL wrap_full_empty got=%b want=0", empty); end
        vecs++; if (almost_empty !== 1'b0) begin errs++; $display("FAIL wrap_full_ae got=%b want=0", almost_empty); end
        read_inc = 1'b1;
        step(16);
        read_inc = 1'b0;
        vecs++; if (read_ptr !== 5'b11000) begin errs++; $display("FAIL wrap_lap1_ptr got=%b want=11000", read_ptr); end
        vecs++; if (read_addr !== 4'd0) begin errs++; $display("FAIL wrap_lap1_addr got=%0d want=0", read_addr); end
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL wrap_lap1_empty got=%b want=1", empty); end
        vecs++; if (read_count !== 5'd0) begin errs++; $display("FAIL wrap_lap1_count got=%0d want=0", read_count); end
        vecs++; if (underflow !== 1'b0) begin errs++; $display("FAIL wrap_lap1_underflow got=%b want=0", underflow); end
        write_ptr = 5'b00000;
        step(3);
        vecs++; if (read_count !== 5'd16) begin errs++; $display("FAIL wrap_lap2_count got=%0d want=16", read_count); end
        vecs++; if (empty !== 1'b0) begin errs++; $display("FAIL wrap_lap2_empty got=%b want=0", empty); end
        read_inc = 1'b1;
        step(8);
        vecs++; if (read_addr !== 4'd8) begin errs++; $display("FAIL wrap_mid_addr got=%0d want=8", read_addr); end
        vecs++; if (read_ptr !== 5'b10100) begin errs++; $display("FAIL wrap_mid_ptr got=%b want=10100", read_ptr); end
        vecs++; if (read_count !== 5'd8) begin errs++; $display("FAIL wrap_mid_count got=%0d want=8", read_count); end
        step(8);
        read_inc = 1'b0;
        vecs++; if (read_ptr !== 5'b00000) begin errs++; $display("FAIL wrap_lap2_ptr got=%b want=00000", read_ptr); end
        vecs++; if (read_addr !== 4'd0) begin errs++; $display("FAIL wrap_lap2_addr got=%0d want=0", read_addr); end
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL wrap_lap2_end_empty got=%b want=1", empty); end
        vecs++; if (underflow !== 1'b0) begin errs++; $display("FAIL wrap_lap2_underflow got=%b want=0", underflow); end
    endtask

    task automatic test_threshold();
        apply_reset();
        write_ptr = 5'b00010;
        step(3);
        vecs++; if (read_count !== 5'd3) begin errs++; $display("FAIL thr_count3 got=%0d want=3", read_count); end
        vecs++; if (almost_empty !== 1'b0) begin errs++; $display("FAIL thr_ae_at3 got=%b want=0", almost_empty); end
        read_inc = 1'b1;
        step(1);
        read_inc = 1'b0;
        vecs++; if (read_count !== 5'd2) begin errs++; $display("FAIL thr_count2 got=%0d want=2", read_count); end
        vecs++; if (almost_empty !== 1'b1) begin errs++; $display("FAIL thr_ae_at2 got=%b want=1", almost_empty); end
        vecs++; if (empty !== 1'b0) begin errs++; $display("FAIL thr_empty_at2 got=%b want=0", empty); end
    endtask

    task automatic test_back_to_back();
        // Continues from threshold state: rbin=1, write side at 3; write advances to 5 while a pop lands.
        write_ptr = 5'b00111;
        step(2);
        vecs++; if (read_count !== 5'd2) begin errs++; $display("FAIL b2b_pre_count got=%0d want=2", read_count); end
        read_inc = 1'b1;
        step(1);
        read_inc = 1'b0;
        vecs++; if (read_count !== 5'd3) begin errs++; $display("FAIL b2b_count got=%0d want=3", read_count); end
        vecs++; if (almost_empty !== 1'b0) begin errs++; $display("FAIL b2b_ae got=%b want=0", almost_empty); end
        vecs++; if (read_addr !== 4'd2) begin errs++; $display("FAIL b2b_addr got=%0d want=2", read_addr); end
        vecs++; if (read_ptr !== 5'b00011) begin errs++; $display("FAIL b2b_ptr got=%b want=00011", read_ptr); end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        write_ptr = 5'b01010;
        step(3);
        read_inc = 1'b1;
        step(7);
        vecs++; if (read_addr !== 4'd7) begin errs++; $display("FAIL mrst_pre_addr got=%0d want=7", read_addr); end
        vecs++; if (read_count !== 5'd5) begin errs++; $display("FAIL mrst_pre_count got=%0d want=5", read_count); end
        read_reset = 1'b1;
        step(1);
        read_reset = 1'b0;
        read_inc   = 1'b0;
        vecs++; if (read_addr !== 4'd0) begin errs++; $display("FAIL mrst_addr got=%0d want=0", read_addr); end
        vecs++; if (read_ptr !== 5'b00000) begin errs++; $display("FAIL mrst_ptr got=%b want=00000", read_ptr); end
        vecs++; if (read_count !== 5'd0) begin errs++; $display("FAIL mrst_count got=%0d want=0", read_count); end
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL mrst_empty got=%b want=1", empty); end
        vecs++; if (almost_empty !== 1'b1) begin errs++; $display("FAIL mrst_ae got=%b want=1", almost_empty); end
        vecs++; if (underflow !== 1'b0) begin errs++; $display("FAIL mrst_underflow got=%b want=0", underflow); end
        step(2);
        vecs++; if (read_count !== 5'd0) begin errs++; $display("FAIL mrst_sync_cleared got=%0d want=0", read_count); end
        step(1);
        vecs++; if (read_count !== 5'd12) begin errs++; $display("FAIL mrst_resync_count got=%0d want=12", read_count); end
        vecs++; if (empty !== 1'b0) begin errs++; $display("FAIL mrst_resync_empty got=%b want=0", empty); end
    endtask

    initial begin
        read_reset = 1'b1;
        read_inc   = 1'b0;
        write_ptr  = 5'b00000;
        step(1);
        test_reset();
        test_single_entry();
        test_underflow();
        test_wrap();
        test_threshold();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
